// File: rtl/ram32_byte_ctrl.sv
// Byte-serial command front end for a 32-word x 32-bit RAM.
// Collects 4 write bytes per word and returns read words 1 byte at a time, LSB first.
module ram32_byte_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_byte,
  output logic              cmd_ready,
  output logic              rdata_valid,
  output logic [7:0]        rdata_byte,
  input  logic              rdata_ready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_a,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_di,
  input  logic [31:0]       ram_do
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_WRITE  = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_CAP = 3'd4,
    S_RD_OUT = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_ram_a;
  logic [31:0]         r_ram_di;
  logic [31:0]         r_shift;
  logic [1:0]          r_cnt;

  logic                w_cmd_ready;
  logic                w_access;
  logic [3:0]          w_we;
  logic                w_rd_valid;
  logic                w_cmd_hs;
  logic                w_rd_hs;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [31:0]         w_di_nxt;
  logic                w_unused;

  // Bit 5 of a command byte carries no meaning.
  assign w_unused   = cmd_byte[5];
  assign w_cmd_addr = cmd_byte[6] ? r_ptr : cmd_byte[ADDR_W-1:0];
  assign w_cmd_hs   = cmd_valid & w_cmd_ready;
  assign w_rd_hs    = w_rd_valid & rdata_ready;

  // State decode; every strobe is gated by ena so a frozen block stays quiet.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_access    = 1'b0;
    w_we        = 4'h0;
    w_rd_valid  = 1'b0;
    case (r_state)
      S_IDLE, S_WDATA: w_cmd_ready = ena;
      S_WRITE: begin
        w_access = ena;
        w_we     = {4{ena}};
      end
      S_RD_REQ: w_access   = ena;
      S_RD_OUT: w_rd_valid = ena;
      default: begin
        w_cmd_ready = 1'b0;
        w_access    = 1'b0;
      end
    endcase
  end

  // Merge the incoming write byte into its lane.
  always_comb begin
    w_di_nxt = r_ram_di;
    case (r_cnt)
      2'd0:    w_di_nxt[7:0]   = cmd_byte;
      2'd1:    w_di_nxt[15:8]  = cmd_byte;
      2'd2:    w_di_nxt[23:16] = cmd_byte;
      2'd3:    w_di_nxt[31:24] = cmd_byte;
      default: w_di_nxt = r_ram_di;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = cmd_byte[7] ? S_WDATA : S_RD_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WDATA: begin
        if (w_cmd_hs && (r_cnt == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_WDATA;
        end
      end
      S_WRITE: begin
        if (ena) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_RD_REQ: begin
        if (ena) begin
          w_state_nxt = S_RD_CAP;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_RD_CAP: begin
        if (ena) begin
          w_state_nxt = S_RD_OUT;
        end else begin
          w_state_nxt = S_RD_CAP;
        end
      end
      S_RD_OUT: begin
        if (w_rd_hs && (r_cnt == 2'd3)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RD_OUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: ram_a only moves when an access is about to start, so it holds between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_addr   <= '0;
      r_ram_a  <= '0;
      r_ram_di <= 32'h0000_0000;
      r_shift  <= 32'h0000_0000;
      r_cnt    <= 2'd0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_addr <= w_cmd_addr;
            r_cnt  <= 2'd0;
            if (!cmd_byte[7]) begin
              r_ram_a <= w_cmd_addr;
            end
          end
        end
        S_WDATA: begin
          if (w_cmd_hs) begin
            r_ram_di <= w_di_nxt;
            r_cnt    <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_ram_a <= r_addr;
            end
          end
        end
        S_WRITE, S_RD_REQ: r_ptr <= r_ram_a + ADDR_W'(1);
        S_RD_CAP: r_shift <= ram_do;
        S_RD_OUT: begin
          if (w_rd_hs) begin
            r_shift <= {8'h00, r_shift[31:8]};
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign rdata_valid = w_rd_valid;
  assign rdata_byte  = r_shift[7:0];
  assign ram_en      = w_access;
  assign ram_we      = w_we;
  assign ram_a       = r_ram_a;
  assign ram_di      = r_ram_di;

endmodule

// File: tb/tb_ram32_byte_ctrl.sv
// Scoreboard bench for ram32_byte_ctrl: stimulus pushes expected RAM accesses and
// read bytes into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ram32_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        cmd_ready;
  logic        rdata_valid;
  logic [7:0]  rdata_byte;
  logic        rdata_ready;
  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  typedef struct packed {
    logic [4:0]  a;
    logic [3:0]  we;
    logic [31:0] di;
  } ram_exp_t;

  ram_exp_t    ram_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] mem [32];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ram32_byte_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .rdata_valid(rdata_valid), .rdata_byte(rdata_byte), .rdata_ready(rdata_ready),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  // Synchronous RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_we[k]) mem[ram_a][8*k +: 8] <= ram_di[8*k +: 8];
      end
      if (ram_we == 4'h0) ram_do <= mem[ram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every RAM access and every accepted read byte against the queues
  always @(negedge clk) begin
    ram_exp_t e;
    logic [7:0] b;
    if (rst_n && ram_en) begin
      if (ram_q.size() == 0) begin
        check("ram_unexpected_access", 32'd1, 32'd0);
      end else begin
        e = ram_q.pop_front();
        check("ram_a", {27'd0, ram_a}, {27'd0, e.a});
        check("ram_we", {28'd0, ram_we}, {28'd0, e.we});
        check("ram_di", ram_di, e.di);
      end
    end
    if (rst_n && rdata_valid && rdata_ready) begin
      if (rd_q.size() == 0) begin
        check("rdata_unexpected", 32'd1, 32'd0);
      end else begin
        b = rd_q.pop_front();
        check("rdata_byte", {24'd0, rdata_byte}, {24'd0, b});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_byte  = b;
    while (!done) begin
      @(negedge clk);
      done = cmd_ready;
      tick();
      n++;
      if (!done && n > 50) begin
        check("cmd_accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((ram_q.size() != 0 || rd_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    check("drain_queues", ram_q.size() + rd_q.size(), 32'd0);
  endtask

  task automatic push_read(input logic [4:0] a, input logic [31:0] di, input logic [31:0] word);
    ram_q.push_back('{a: a, we: 4'h0, di: di});
    for (int k = 0; k < 4; k++) rd_q.push_back(word[8*k +: 8]);
  endtask

  // Read whose first byte arrival is timed from the acceptance edge
  task automatic timed_read(input logic [7:0] cmd);
    int lat;
    send_byte(cmd);
    lat = 1;
    @(negedge clk);
    check("rd_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    while (!rdata_valid && lat < 20) begin
      tick();
      lat++;
      @(negedge clk);
    end
    check("rd_latency", lat, 32'd3);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0000;
    ram_do      = 32'h0000_0000;
    rst_n       = 1'b1;
    ena         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_byte    = 8'h00;
    rdata_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {28'd0, ram_we}, 32'd0);
    check("rst_ram_a", {27'd0, ram_a}, 32'd0);
    check("rst_ram_di", ram_di, 32'd0);
    check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_rdata_byte", {24'd0, rdata_byte}, 32'd0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready_ena1", {31'd0, cmd_ready}, 32'd1);
    ena = 1'b0;
    #1 check("idle_cmd_ready_ena0", {31'd0, cmd_ready}, 32'd0);
    ena = 1'b1;
    tick();

    // Write 0x44332211 to address 5
    ram_q.push_back('{a: 5'd5, we: 4'hF, di: 32'h4433_2211});
    send_byte(8'h85);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clk);
    check("wr_latency_ram_en", {31'd0, ram_en}, 32'd1);
    tick();
    @(negedge clk);
    check("wr_single_cycle", {31'd0, ram_en}, 32'd0);
    check("wr_ram_a_hold", {27'd0, ram_a}, 32'd5);
    tick();
    wait_drain();

    // Read back address 5
    push_read(5'd5, 32'h4433_2211, 32'h4433_2211);
    timed_read(8'h05);
    wait_drain();

    // Write address 31, then pointer-mode write wraps to address 0
    ram_q.push_back('{a: 5'd31, we: 4'hF, di: 32'hDDCC_BBAA});
    send_byte(8'h9F);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    ram_q.push_back('{a: 5'd0, we: 4'hF, di: 32'h0403_0201});
    send_byte(8'hC0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    wait_drain();
    check("mem31", mem[31], 32'hDDCC_BBAA);
    check("mem0", mem[0], 32'h0403_0201);

    // Backpressure on read byte 1
    push_read(5'd5, 32'h0403_0201, 32'h4433_2211);
    timed_read(8'h05);
    rdata_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rdata_byte", {24'd0, rdata_byte}, 32'h22);
      check("bp_rdata_valid", {31'd0, rdata_valid}, 32'd1);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    rdata_ready = 1'b1;
    wait_drain();

    // Reset after two write bytes discards the partial word
    send_byte(8'h8A);
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check("midrst_ram_di", ram_di, 32'd0);
    check("midrst_ram_en", {31'd0, ram_en}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    ram_q.push_back('{a: 5'd0, we: 4'hF, di: 32'hAA99_8877});
    send_byte(8'h80);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    send_byte(8'hAA);
    wait_drain();
    check("midrst_mem10", mem[10], 32'd0);

    // ena low during the read access cycle
    push_read(5'd0, 32'hAA99_8877, 32'hAA99_8877);
    send_byte(8'h00);
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ena0_ram_en", {31'd0, ram_en}, 32'd0);
      check("ena0_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    ena = 1'b1;
    @(negedge clk);
    check("ena_retry_ram_en", {31'd0, ram_en}, 32'd1);
    tick();
    wait_drain();

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
